// File: rtl/abro_driver.sv
// ---------------------------------------------------------------------------
// abro_driver -- stimulus generator and response checker for an ABRO machine.
//
// On an accepted start it issues one A pulse and one B pulse (order and
// spacing captured with start), then watches O_in for up to TIMEOUT cycles
// and reports exactly one outcome: pass, timeout or early.
//
// Parameter:
//   TIMEOUT   max WAIT_O cycles to wait for O_in (legal 1..15, default 8)
//
// Ports:
//   clk       single clock, rising edge
//   reset     asynchronous, active-high reset
//   start     request a sequence; sampled only in IDLE
//   order     0: A then B, 1: B then A (captured with start)
//   gap[3:0]  idle cycles between the two pulses (captured with start)
//   O_in      observed output of the ABRO machine
//   A, B      registered stimulus pulses
//   busy      high in every state except IDLE
//   done      one-cycle completion strobe
//   pass      O_in seen within the window (held until next accepted start)
//   timeout   window expired without O_in (held until next accepted start)
//   early     O_in seen before the second pulse (held until next start)
//   resp_lat  cycles from second pulse to O_in
//
// Build option:
//   ABRO_DRV_LAT_EN  defined: resp_lat is captured; undefined: resp_lat = 0
// ---------------------------------------------------------------------------
module abro_driver #(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       order,
   input  logic [3:0] gap,
   input  logic       O_in,
   output logic       A,
   output logic       B,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       timeout,
   output logic       early,
   output logic [3:0] resp_lat
);

   typedef enum logic [2:0] {
      S_IDLE, S_FIRST, S_GAP, S_SECOND, S_WAIT_O, S_DONE
   } state_t;

   localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;        // shared: GAP length, then WAIT_O count
   logic       order_q, order_d;
   logic [3:0] gap_q, gap_d;
   logic       pass_d, timeout_d, early_d;
   logic       a_d, b_d;
`ifdef ABRO_DRV_LAT_EN
   logic [3:0] lat_q, lat_d;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; otherwise synthesis infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      order_d   = order_q;
      gap_d     = gap_q;
      pass_d    = pass;
      timeout_d = timeout;
      early_d   = early;
`ifdef ABRO_DRV_LAT_EN
      lat_d     = lat_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               order_d   = order;
               gap_d     = gap;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               early_d   = 1'b0;
`ifdef ABRO_DRV_LAT_EN
               lat_d     = 4'd0;
`endif
               state_d   = S_FIRST;
            end
         end
         S_FIRST: begin
            if (O_in) begin
               early_d = 1'b1;
               state_d = S_DONE;
            end else if (gap_q != 4'd0) begin
               cnt_d   = 4'd1;
               state_d = S_GAP;
            end else begin
               state_d = S_SECOND;
            end
         end
         S_GAP: begin
            if (O_in) begin
               early_d = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == gap_q) begin
               state_d = S_SECOND;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SECOND: begin
            cnt_d   = 4'd1;         // first WAIT_O cycle is count 1
            state_d = S_WAIT_O;
         end
         S_WAIT_O: begin
            // O_in wins over expiry, so a response on the last cycle passes.
            if (O_in) begin
               pass_d  = 1'b1;
`ifdef ABRO_DRV_LAT_EN
               lat_d   = cnt_q;
`endif
               state_d = S_DONE;
            end else if (cnt_q == TIMEOUT_C) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Pulses are decoded from the next state so they can be registered and
      // line up with the state they belong to; only one can ever be set.
      a_d = ((state_d == S_FIRST) && !order_d) || ((state_d == S_SECOND) && order_d);
      b_d = ((state_d == S_FIRST) && order_d)  || ((state_d == S_SECOND) && !order_d);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         order_q <= 1'b0;
         gap_q   <= 4'd0;
         A       <= 1'b0;
         B       <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         timeout <= 1'b0;
         early   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         order_q <= order_d;
         gap_q   <= gap_d;
         A       <= a_d;
         B       <= b_d;
         busy    <= (state_d != S_IDLE);
         done    <= (state_d == S_DONE);
         pass    <= pass_d;
         timeout <= timeout_d;
         early   <= early_d;
      end
   end

`ifdef ABRO_DRV_LAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lat_q <= 4'd0;
      else       lat_q <= lat_d;
   end
   assign resp_lat = lat_q;
`else
   assign resp_lat = 4'd0;
`endif

endmodule

// File: tb/tb_abro_driver.sv
// ---------------------------------------------------------------------------
// tb_abro_driver -- directed self-checking bench for abro_driver (TIMEOUT=8).
// Cycle numbering inside a sequence: cycle 1 is the first cycle after the
// clock edge that samples start. Outputs are sampled 1 time unit after each
// rising edge; inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_abro_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       order = 1'b0;
   logic [3:0] gap = 4'd0;
   logic       O_in = 1'b0;
   logic       A, B, busy, done, pass, timeout, early;
   logic [3:0] resp_lat;

   int checks = 0;
   int errors = 0;

   abro_driver #(.TIMEOUT(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .order    (order),
      .gap      (gap),
      .O_in     (O_in),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .timeout  (timeout),
      .early    (early),
      .resp_lat (resp_lat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] lat_exp(input logic [3:0] v);
`ifdef ABRO_DRV_LAT_EN
      return v;
`else
      return (v == 4'd0) ? 4'd0 : 4'd0;
`endif
   endfunction

   // Run one sequence from IDLE. O_in is high for cycles o_from..o_to.
   // exp_a/exp_b/exp_done: cycle of first A, B, done (0 = never).
   task automatic go(input string tag, input logic ord, input logic [3:0] gp,
                     input int o_from, input int o_to,
                     input int exp_a, input int exp_b, input int exp_done,
                     input logic exp_pass, input logic exp_to, input logic exp_early,
                     input logic [3:0] exp_lat);
      int a_c, b_c, done_c, n_a, n_b;
      logic both;
      logic [6:0] flags;
      a_c = 0; b_c = 0; done_c = 0; n_a = 0; n_b = 0; both = 1'b0; flags = '0;
      start = 1'b1; order = ord; gap = gp; O_in = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 1) check({tag, "_flags_cleared"}, {pass, timeout, early}, 3'b000);
         if (A) begin n_a++; if (a_c == 0) a_c = c; end
         if (B) begin n_b++; if (b_c == 0) b_c = c; end
         both |= A & B;
         if (done && done_c == 0) begin
            done_c = c;
            flags  = {pass, timeout, early, resp_lat};
         end
         if (done_c != 0) break;
         O_in = (c >= o_from) && (c <= o_to);
         tick();
      end
      O_in = 1'b0;
      check({tag, "_a_cycle"}, a_c, exp_a);
      check({tag, "_b_cycle"}, b_c, exp_b);
      check({tag, "_done_cycle"}, done_c, exp_done);
      check({tag, "_pulse_count"}, {n_a[7:0], n_b[7:0]},
            {8'((exp_a != 0) ? 1 : 0), 8'((exp_b != 0) ? 1 : 0)});
      check({tag, "_ab_exclusive"}, both, 1'b0);
      check({tag, "_outcome"}, flags, {exp_pass, exp_to, exp_early, lat_exp(exp_lat)});
      tick();
      check({tag, "_back_idle"}, {busy, done, pass, timeout, early},
            {1'b0, 1'b0, exp_pass, exp_to, exp_early});
   endtask

   initial begin
      logic [63:0] a_mask, b_mask, d_mask;

      // Reset: outputs forced to 0 without a clock edge.
      #2 reset = 1'b1;
      #1 check("reset_async", {A, B, busy, done, pass, timeout, early, resp_lat}, 11'd0);
      tick();
      reset = 1'b0;
      tick();
      check("reset_idle", {A, B, busy, done}, 4'b0000);

      //  tag          ord  gap  o_from o_to  a   b   done pass to  early lat
      go("ord0_gap2",  1'b0, 4'd2,  5,  5,    1,  4,  6,  1'b1, 1'b0, 1'b0, 4'd1);
      go("ord1_tmo",   1'b1, 4'd0,  0, -1,    2,  1, 11,  1'b0, 1'b1, 1'b0, 4'd0);
      go("early_gap",  1'b0, 4'd3,  3,  3,    1,  0,  4,  1'b0, 1'b0, 1'b1, 4'd0);
      go("last_cycle", 1'b0, 4'd0, 10, 10,    1,  2, 11,  1'b1, 1'b0, 1'b0, 4'd8);
      go("min_seq",    1'b1, 4'd0,  3,  3,    2,  1,  4,  1'b1, 1'b0, 1'b0, 4'd1);
      go("early_1st",  1'b1, 4'd5,  1,  1,    0,  1,  2,  1'b0, 1'b0, 1'b1, 4'd0);
      go("gap_max",    1'b0, 4'd15, 18, 20,   1, 17, 19,  1'b1, 1'b0, 1'b0, 4'd1);

      // Reset mid-sequence (during GAP), then a fresh B-first sequence.
      start = 1'b1; order = 1'b0; gap = 4'd4;
      tick();
      start = 1'b0;
      tick(); tick();                       // cycle 3: in GAP
      check("pre_reset_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1 check("reset_mid_async", {A, B, busy, done, pass, timeout, early, resp_lat}, 11'd0);
      tick();
      check("reset_mid_held", {A, B, busy, done, pass, timeout, early, resp_lat}, 11'd0);
      #2 reset = 1'b0;
      tick(); tick();
      check("reset_wait_idle", {A, B, busy, done}, 4'b0000);
      go("after_reset", 1'b1, 4'd1, 4, 4,   3,  1,  5,  1'b1, 1'b0, 1'b0, 4'd1);

      // start held high for three sequences; order/gap changed while busy.
      a_mask = '0; b_mask = '0; d_mask = '0;
      start = 1'b1; order = 1'b0; gap = 4'd1; O_in = 1'b0;
      tick();
      for (int c = 1; c <= 37; c++) begin
         if (A)    a_mask[c] = 1'b1;
         if (B)    b_mask[c] = 1'b1;
         if (done) d_mask[c] = 1'b1;
         if (c == 13) check("hold_idle_between", busy, 1'b0);
         if (c == 2) begin order = 1'b1; gap = 4'd0; end
         if (c == 37) start = 1'b0;
         tick();
      end
      check("hold_a_cycles", a_mask, (64'd1 << 1) | (64'd1 << 15) | (64'd1 << 27));
      check("hold_b_cycles", b_mask, (64'd1 << 3) | (64'd1 << 14) | (64'd1 << 26));
      check("hold_done_cycles", d_mask, (64'd1 << 12) | (64'd1 << 24) | (64'd1 << 36));
      tick(); tick();
      check("hold_ends_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
